// File: rtl/fnd_scheduler.sv
// Round-robin FND display scheduler with one-cycle blank gap between sources.
// Optional source-0 override: FND_SCHED_PRIORITY_EN.
module fnd_scheduler #(
  parameter int DWELL_CYCLES = 100
) (
  input  logic        iCLK,
  input  logic        inReset,
  input  logic [3:0]  iReq,
  input  logic [31:0] iHexBus,
  input  logic [3:0]  iModeBus,
  output logic [7:0]  oHex,
  output logic        oMode,
  output logic        oBlank,
  output logic [3:0]  oGrant,
  output logic [1:0]  oSrc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    SWITCH = 2'd2
  } state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  src_q, src_d;
  logic [1:0]  last_q, last_d;
  logic [15:0] dwell_q, dwell_d;

  logic [7:0]  hex_q, hex_d;
  logic        mode_q, mode_d;
  logic        blank_q, blank_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  osrc_q, osrc_d;

  logic [1:0]  win_idx;
  logic        win_hit;

  // Search starts just after the last grant and wraps back to it.
  always_comb begin
    logic [1:0] idx;
    idx     = '0;
    win_idx = '0;
    win_hit = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!win_hit && iReq[idx]) begin
        win_hit = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (inReset) begin
      state_q <= IDLE;
      src_q   <= '0;
      last_q  <= 2'd3;
      dwell_q <= '0;
      hex_q   <= '0;
      mode_q  <= 1'b0;
      blank_q <= 1'b1;
      grant_q <= '0;
      osrc_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      hex_q   <= hex_d;
      mode_q  <= mode_d;
      blank_q <= blank_d;
      grant_q <= grant_d;
      osrc_q  <= osrc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    unique case (state_q)
      IDLE, SWITCH: begin
        if (win_hit) begin
          state_d = SHOW;
          src_d   = win_idx;
          last_d  = win_idx;
          dwell_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHOW: begin
        if (!iReq[src_q] || dwell_q == DWELL_LAST) begin
          state_d = (|iReq) ? SWITCH : IDLE;
        end else begin
          dwell_d = dwell_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef FND_SCHED_PRIORITY_EN
    // Override grants leave the round-robin pointer untouched.
    if (iReq[0]) begin
      if (!(state_q == SHOW && src_q == 2'd0)) begin
        state_d = SHOW;
        src_d   = 2'd0;
        last_d  = last_q;
        dwell_d = '0;
      end else begin
        state_d = SHOW;
        dwell_d = dwell_q;
      end
    end
`endif
  end

  always_comb begin
    hex_d   = '0;
    mode_d  = 1'b0;
    blank_d = 1'b1;
    grant_d = '0;
    osrc_d  = '0;
    if (state_d == SHOW) begin
      hex_d   = iHexBus[{src_d, 3'b000} +: 8];
      mode_d  = iModeBus[src_d];
      blank_d = 1'b0;
      grant_d = 4'b0001 << src_d;
      osrc_d  = src_d;
    end
  end

  assign oHex   = hex_q;
  assign oMode  = mode_q;
  assign oBlank = blank_q;
  assign oGrant = grant_q;
  assign oSrc   = osrc_q;

endmodule

// File: tb/tb_fnd_scheduler.sv
// Directed scoreboard bench for fnd_scheduler (DWELL_CYCLES=4).
module tb_fnd_scheduler;

  logic        iCLK;
  logic        inReset;
  logic [3:0]  iReq;
  logic [31:0] iHexBus;
  logic [3:0]  iModeBus;
  logic [7:0]  oHex;
  logic        oMode;
  logic        oBlank;
  logic [3:0]  oGrant;
  logic [1:0]  oSrc;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic [7:0] h;
    logic       m;
    logic       b;
    logic       sw;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_pass;
  int   n_fail;

  fnd_scheduler #(.DWELL_CYCLES(4)) dut (
    .iCLK    (iCLK),
    .inReset (inReset),
    .iReq    (iReq),
    .iHexBus (iHexBus),
    .iModeBus(iModeBus),
    .oHex    (oHex),
    .oMode   (oMode),
    .oBlank  (oBlank),
    .oGrant  (oGrant),
    .oSrc    (oSrc)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk_step(input string tag, input exp_t e);
    exp_t x;
    q.push_back(e);
    @(posedge iCLK);
    #1;
    x = q.pop_front();
    n_chk++;
    assert ({oGrant, oHex, oBlank} === {x.g, x.h, x.b}) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s grant/hex/blank got %b/%h/%b want %b/%h/%b",
             tag, oGrant, oHex, oBlank, x.g, x.h, x.b);
    end
    if (!x.sw) begin
      n_chk++;
      assert ({oSrc, oMode} === {x.s, x.m}) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s src/mode got %0d/%b want %0d/%b",
               tag, oSrc, oMode, x.s, x.m);
      end
    end
  endtask

  task automatic idle(input string tag);
    chk_step(tag, '{g: 4'b0, s: 2'd0, h: 8'h00, m: 1'b0, b: 1'b1, sw: 1'b0});
  endtask

  task automatic gap(input string tag);
    chk_step(tag, '{g: 4'b0, s: 2'd0, h: 8'h00, m: 1'b0, b: 1'b1, sw: 1'b1});
  endtask

  task automatic show(input string tag, input logic [1:0] i,
                      input logic [7:0] h, input logic m);
    chk_step(tag, '{g: 4'b0001 << i, s: i, h: h, m: m, b: 1'b0, sw: 1'b0});
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    n_fail   = 0;
    inReset  = 1'b1;
    iHexBus  = 32'h7742_0513;
    iModeBus = 4'b0000;
`ifdef FND_SCHED_PRIORITY_EN
    iReq = 4'b0000;
    idle("p_rst");
    inReset = 1'b0;
    iReq = 4'b0100;
    show("p_s2", 2'd2, 8'h42, 1'b0);
    iReq = 4'b0101;
    for (int i = 0; i < 20; i++) show("p_hold0", 2'd0, 8'h13, 1'b0);
    iReq = 4'b0100;
    gap("p_sw");
    show("p_back2", 2'd2, 8'h42, 1'b0);
`else
    iReq = 4'hF;
    idle("rst0");
    idle("rst1");
    inReset = 1'b0;
    show("rel_s0", 2'd0, 8'h13, 1'b0);
    iReq = 4'b0101;
    for (int i = 0; i < 3; i++) show("dw_s0", 2'd0, 8'h13, 1'b0);
    gap("dw_sw0");
    for (int i = 0; i < 4; i++) show("dw_s2", 2'd2, 8'h42, 1'b0);
    gap("dw_sw2");
    show("dw_back0", 2'd0, 8'h13, 1'b0);
    iReq = 4'b1010;
    gap("drop_s0");
    iModeBus = 4'b0010;
    show("rr_s1", 2'd1, 8'h05, 1'b1);
    iHexBus[15:8] = 8'h09;
    show("live", 2'd1, 8'h09, 1'b1);
    iReq = 4'b1000;
    gap("drop_s1");
    show("rr_s3", 2'd3, 8'h77, 1'b0);
    for (int i = 0; i < 2; i++) show("s3_dw", 2'd3, 8'h77, 1'b0);
    inReset = 1'b1;
    idle("rst_mid");
    inReset = 1'b0;
    show("post_rst", 2'd3, 8'h77, 1'b0);
    for (int i = 0; i < 3; i++) show("solo_dw", 2'd3, 8'h77, 1'b0);
    gap("regrant_sw");
    show("regrant", 2'd3, 8'h77, 1'b0);
    iReq = 4'b0000;
    idle("drop_idle");
    idle("stay_idle");
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fnd_scheduler.md
FND_SCHEDULER -- requirements
Module: fnd_scheduler

Interface
REQ-001 Parameter DWELL_CYCLES, default 100, is the number of clock cycles one source is displayed per turn; the legal range is 2..65535.
REQ-002 Port iCLK  input  1: the single clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port inReset  input  1: the reset, which SHALL be synchronous and active-high.
REQ-004 Port iReq  input  4: per-source display request, where bit n is source n.
REQ-005 Port iHexBus  input  32: source values, where bits [8n+7:8n] are source n.
REQ-006 Port iModeBus  input  4: per-source display mode, where 0 is decimal and 1 is hex.
REQ-007 Port oHex  output  8: the value presented to the FND driver.
REQ-008 Port oMode  output  1: the display mode presented to the FND driver.
REQ-009 Port oBlank  output  1: when 1, the FND driver SHALL blank the digits.
REQ-010 Port oGrant  output  4: one-hot grant to the source currently displayed, or all zeros when no source is displayed.
REQ-011 Port oSrc  output  2: the index of the granted source; it is valid only when oGrant is nonzero.

Function
REQ-012 The block SHALL implement a state machine with three states: IDLE, SHOW and SWITCH.
REQ-013 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-014 Arbitration SHALL be round-robin: the search starts at (last+1) mod 4, where last is the most recently granted source, and the first source with iReq set wins.
REQ-015 IDLE: if iReq is nonzero at a clock edge, the next state SHALL be SHOW with the arbitration winner granted; otherwise the state SHALL remain IDLE.
REQ-016 SHOW: oGrant SHALL be one-hot, oSrc SHALL equal the winner, and oBlank SHALL be 0.
REQ-017 SHOW: oHex and oMode SHALL be loaded every cycle from the granted source's slice, giving a latency of 1 cycle from input to output.
REQ-018 SHOW SHALL last exactly DWELL_CYCLES cycles, counted by a dwell counter that is cleared on entry to SHOW.
REQ-019 At the end of the dwell, the next state SHALL be SWITCH if iReq is nonzero, otherwise IDLE.
REQ-020 If the granted source's iReq bit is 0 during SHOW, the block SHALL leave SHOW at the next edge: to SWITCH if any other iReq bit is set, otherwise to IDLE.
REQ-021 SWITCH SHALL last exactly 1 cycle, with oBlank=1, oGrant=0 and oHex=0 (anti-ghost gap).
REQ-022 At the SWITCH edge, the block SHALL arbitrate and enter SHOW with the winner, or IDLE if iReq is 0.
REQ-023 If the only requester is the source just shown, that source SHALL be re-granted after one SWITCH cycle.
REQ-024 IDLE: oBlank=1, oGrant=0, oSrc=0, oHex=0 and oMode=0.
REQ-025 Requests arriving during SHOW SHALL NOT shorten the dwell, except as defined in REQ-020 and REQ-034.

Reset
REQ-026 With inReset=1 at a clock edge, the next state SHALL be IDLE, regardless of the current state.
REQ-027 Reset SHALL set: dwell counter=0, last=3 (so source 0 wins first), oHex=0, oMode=0, oBlank=1, oGrant=0, oSrc=0.
REQ-028 Reset SHALL take priority over all state transitions, including reset asserted in the middle of a dwell.

Configuration
REQ-029 The macro FND_SCHED_PRIORITY_EN SHALL select whether source 0 has an override.
REQ-030 With FND_SCHED_PRIORITY_EN defined, an iReq[0]=1 seen in IDLE, SHOW (granted source not 0) or SWITCH SHALL cause a transition to SHOW with source 0 at the next edge, with no SWITCH gap.
REQ-031 With FND_SCHED_PRIORITY_EN defined, source 0 SHALL hold SHOW without a dwell limit while iReq[0]=1.
REQ-032 With FND_SCHED_PRIORITY_EN defined, when iReq[0] falls the block SHALL behave as in REQ-020.
REQ-033 With FND_SCHED_PRIORITY_EN defined, the round-robin pointer last SHALL NOT be updated by override grants.
REQ-034 Without FND_SCHED_PRIORITY_EN, source 0 SHALL be an ordinary round-robin participant and REQ-030 to REQ-033 SHALL NOT apply.

Verification
REQ-035 Reset: hold inReset=1 for 2 cycles with iReq=4'hF; this SHALL give oBlank=1, oGrant=0 and oHex=0. After release, source 0 SHALL be granted at the next edge.
REQ-036 Dwell: DWELL_CYCLES=4, iReq=4'b0101, iHexBus[7:0]=8'h13, iHexBus[23:16]=8'h42, iModeBus=0. The required response is grant 0001 for 4 cycles with oHex=8'h13, then SWITCH for 1 cycle, then grant 0100 for 4 cycles with oHex=8'h42, then back to source 0.
REQ-037 Early drop: drop iReq[1] in cycle 2 of source 1's SHOW with iReq[3]=1; SWITCH SHALL follow at the next edge, then source 3 SHALL be granted.
REQ-038 Live update: change iHexBus[15:8] from 8'h05 to 8'h09 during SHOW of source 1; oHex SHALL become 8'h09 exactly 1 cycle later.
REQ-039 Reset mid-dwell: assert inReset at dwell count 2; the next cycle SHALL be IDLE with all outputs at their reset values.
REQ-040 FND_SCHED_PRIORITY_EN: during SHOW of source 2, assert iReq[0]. Source 0 SHALL be granted at the next edge with no blank cycle, and SHALL be held for 20 cycles with DWELL_CYCLES=4; after iReq[0] drops, SWITCH SHALL follow, then source 2 SHALL be granted again.
